// File: rtl/chess_pkg.sv
// Shared definitions for the move generator: piece/colour codes, move-word
// layout and the sequencer state encoding.
package chess_pkg;

  localparam int MOVE_W    = 15;
  localparam int FIELD_W   = 3;
  localparam int PIECE_LSB = 0;
  localparam int DST_Y_LSB = 3;
  localparam int DST_X_LSB = 6;
  localparam int SRC_Y_LSB = 9;
  localparam int SRC_X_LSB = 12;

  typedef logic [MOVE_W-1:0] move_t;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    PAWN    = 3'd1,
    KNIGHT  = 3'd2,
    BISHOP  = 3'd3,
    ROOK    = 3'd4,
    QUEEN   = 3'd5,
    KING    = 3'd6,
    NOTUSED = 3'd7
  } piece_e;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } color_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PROP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  function automatic piece_e move_piece(input move_t m);
    return piece_e'(m[PIECE_LSB +: FIELD_W]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over the column FIFOs; search starts at the pointer and
// the pointer moves just past each granted column.
module rr_arbiter #(
  parameter int NCOL = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [NCOL-1:0]          req,
  output logic [NCOL-1:0]          grant,
  output logic [$clog2(NCOL)-1:0]  grant_idx,
  output logic                     grant_vld
);

  localparam int PW = $clog2(NCOL);

  logic [PW-1:0] rr_ptr;
  logic          found;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NCOL; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NCOL) idx = idx - NCOL;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_vld = en && found;
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (clr) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      if (int'(grant_idx) == NCOL - 1) rr_ptr <= '0;
      else                             rr_ptr <= grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/move_gen_ctrl.sv
// Sweep sequencer: launches one propagation sweep, drains the column move
// FIFOs through a round-robin arbiter and stores the moves in the move-list RAM.
module move_gen_ctrl
  import chess_pkg::*;
#(
  parameter int NCOL        = 8,
  parameter int PROP_CYCLES = 7,
  parameter int ML_AW       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     newboard,
  input  logic [NCOL-1:0]          col_valid,
  input  logic [NCOL*MOVE_W-1:0]   col_move,
  output logic [NCOL-1:0]          col_pop,
  output logic                     ml_wr_en,
  output logic [ML_AW-1:0]         ml_wr_addr,
  output logic [MOVE_W-1:0]        ml_wr_data,
  output logic [ML_AW:0]           move_count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int PW           = $clog2(NCOL);
  localparam int CW           = $clog2(PROP_CYCLES + 1);
  localparam int QUIET_CYCLES = 2;

  state_e         state;
  logic [CW-1:0]  prop_cnt;
  logic [1:0]     quiet_cnt;

  logic           arb_en;
  logic           sweep_clr;
  logic [PW-1:0]  grant_idx;
  logic           grant_vld;
  move_t          gnt_move;

  assign arb_en    = (state == ST_PROP) || (state == ST_DRAIN);
  assign sweep_clr = (state == ST_IDLE) && start;
  assign gnt_move  = col_move[int'(grant_idx)*MOVE_W +: MOVE_W];

  rr_arbiter #(
    .NCOL (NCOL)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (sweep_clr),
    .en        (arb_en),
    .req       (col_valid),
    .grant     (col_pop),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Sequencer: newboard, busy and done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      newboard  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      prop_cnt  <= '0;
      quiet_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            newboard <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          newboard <= 1'b0;
          prop_cnt <= CW'(PROP_CYCLES - 1);
          state    <= ST_PROP;
        end
        ST_PROP: begin
          if (prop_cnt == '0) begin
            state     <= ST_DRAIN;
            quiet_cnt <= '0;
          end else begin
            prop_cnt <= prop_cnt - CW'(1);
          end
        end
        ST_DRAIN: begin
          // Two consecutive empty cycles cover the cells' FIFO write latency.
          if (col_valid != '0) begin
            quiet_cnt <= '0;
          end else if (int'(quiet_cnt) == QUIET_CYCLES - 1) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            quiet_cnt <= quiet_cnt + 2'd1;
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          newboard <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Write stage: one cycle after a pop; moves beyond capacity are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ml_wr_en   <= 1'b0;
      ml_wr_addr <= '0;
      ml_wr_data <= '0;
      move_count <= '0;
      overflow   <= 1'b0;
    end else begin
      ml_wr_en <= 1'b0;
      if (sweep_clr) begin
        move_count <= '0;
        overflow   <= 1'b0;
      end else if (grant_vld) begin
        if (!move_count[ML_AW]) begin
          ml_wr_en   <= 1'b1;
          ml_wr_addr <= move_count[ML_AW-1:0];
          ml_wr_data <= gnt_move;
          move_count <= move_count + (ML_AW+1)'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
